// File: rtl/mem_stage.sv
// Memory-access pipeline stage: EX/MEM bundle in, data-memory req/ready
// access with byte-lane steering and load extension, MEM/WB register out.
module mem_stage #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        valid_i,
    input  logic [31:0] pcsrc_i,
    input  logic [31:0] alu_result_i,
    input  logic [31:0] rs2_data_i,
    input  logic [31:0] offset_i,
    input  logic [1:0]  dmem_to_reg_i,
    input  logic        reg_write_i,
    input  logic [4:0]  rd_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [2:0]  funct3_i,
    output logic        stall_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    input  logic [31:0] dmem_rdata_i,
    input  logic        dmem_ready_i,
    output logic        wb_valid_o,
    output logic        reg_write_o,
    output logic [4:0]  rd_o,
    output logic [1:0]  dmem_to_reg_o,
    output logic [31:0] pcsrc_o,
    output logic [31:0] alu_result_o,
    output logic [31:0] offset_o,
    output logic [31:0] mem_data_read_o,
    output logic        misalign_o,
    output logic        bus_err_o
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Outstanding request
    logic              req_q, req_d, we_q, we_d;
    logic [XLEN-1:0]   addr_q, addr_d, wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;

    // Bundle captured while the access is in flight
    logic [XLEN-1:0]   lat_pc_q, lat_pc_d, lat_alu_q, lat_alu_d, lat_off_q, lat_off_d;
    logic [4:0]        lat_rd_q, lat_rd_d;
    logic              lat_rw_q, lat_rw_d;
    logic [1:0]        lat_d2r_q, lat_d2r_d;
    logic [2:0]        lat_f3_q, lat_f3_d;

    // MEM/WB register
    logic              wbv_q, wbv_d, rw_q, rw_d, mis_q, mis_d, berr_q, berr_d;
    logic [4:0]        rd_q, rd_d;
    logic [1:0]        d2r_q, d2r_d;
    logic [XLEN-1:0]   pc_q, pc_d, alu_q, alu_d, off_q, off_d, mdr_q, mdr_d;

    logic              mem_op_c, misalign_c;
    logic [3:0]        be_c;
    logic [XLEN-1:0]   wdata_c, load_c;
    logic [7:0]        ld_byte_c;
    logic [15:0]       ld_half_c;

    // Store-lane steering and alignment check for the incoming bundle
    always_comb begin
        mem_op_c   = mem_read_i | mem_write_i;
        be_c       = 4'b1111;
        wdata_c    = rs2_data_i;
        misalign_c = 1'b0;
        case (funct3_i[1:0])
            2'b00: begin
                be_c    = 4'b0001 << alu_result_i[1:0];
                wdata_c = {4{rs2_data_i[7:0]}};
            end
            2'b01: begin
                be_c       = alu_result_i[1] ? 4'b1100 : 4'b0011;
                wdata_c    = {2{rs2_data_i[15:0]}};
                misalign_c = alu_result_i[0];
            end
            2'b10:   misalign_c = |alu_result_i[1:0];
            default: misalign_c = 1'b1;
        endcase
    end

    // Load lane select and sign/zero extension using the latched address
    always_comb begin
        case (lat_alu_q[1:0])
            2'd0:    ld_byte_c = dmem_rdata_i[7:0];
            2'd1:    ld_byte_c = dmem_rdata_i[15:8];
            2'd2:    ld_byte_c = dmem_rdata_i[23:16];
            default: ld_byte_c = dmem_rdata_i[31:24];
        endcase
        ld_half_c = lat_alu_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
        case (lat_f3_q[1:0])
            2'b00:   load_c = lat_f3_q[2] ? {24'b0, ld_byte_c} : {{24{ld_byte_c[7]}}, ld_byte_c};
            2'b01:   load_c = lat_f3_q[2] ? {16'b0, ld_half_c} : {{16{ld_half_c[15]}}, ld_half_c};
            default: load_c = dmem_rdata_i;
        endcase
    end

    // Next-state, request and MEM/WB logic; MEM/WB defaults to a bubble
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        lat_pc_d  = lat_pc_q;
        lat_alu_d = lat_alu_q;
        lat_off_d = lat_off_q;
        lat_rd_d  = lat_rd_q;
        lat_rw_d  = lat_rw_q;
        lat_d2r_d = lat_d2r_q;
        lat_f3_d  = lat_f3_q;
        wbv_d     = 1'b0;
        rw_d      = 1'b0;
        mis_d     = 1'b0;
        berr_d    = 1'b0;
        rd_d      = '0;
        d2r_d     = '0;
        pc_d      = '0;
        alu_d     = '0;
        off_d     = '0;
        mdr_d     = '0;
        case (state_q)
            IDLE: begin
                if (valid_i && (!mem_op_c || misalign_c)) begin
                    wbv_d = 1'b1;
                    rw_d  = reg_write_i & ~mem_op_c;
                    mis_d = mem_op_c;
                    rd_d  = rd_i;
                    d2r_d = dmem_to_reg_i;
                    pc_d  = pcsrc_i;
                    alu_d = alu_result_i;
                    off_d = offset_i;
                end else if (valid_i) begin
                    state_d   = BUSY;
                    cnt_d     = '0;
                    req_d     = 1'b1;
                    we_d      = mem_write_i;
                    addr_d    = {alu_result_i[31:2], 2'b00};
                    be_d      = be_c;
                    wdata_d   = mem_write_i ? wdata_c : '0;
                    lat_pc_d  = pcsrc_i;
                    lat_alu_d = alu_result_i;
                    lat_off_d = offset_i;
                    lat_rd_d  = rd_i;
                    lat_rw_d  = reg_write_i;
                    lat_d2r_d = dmem_to_reg_i;
                    lat_f3_d  = funct3_i;
                end
            end
            BUSY: begin
                if (dmem_ready_i || cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    addr_d  = '0;
                    be_d    = '0;
                    wdata_d = '0;
                    wbv_d   = 1'b1;
                    rw_d    = lat_rw_q & dmem_ready_i;
                    berr_d  = ~dmem_ready_i;
                    rd_d    = lat_rd_q;
                    d2r_d   = lat_d2r_q;
                    pc_d    = lat_pc_q;
                    alu_d   = lat_alu_q;
                    off_d   = lat_off_q;
                    mdr_d   = (dmem_ready_i && !we_q) ? load_c : '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, request and pipeline registers
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            lat_pc_q  <= '0;
            lat_alu_q <= '0;
            lat_off_q <= '0;
            lat_rd_q  <= '0;
            lat_rw_q  <= 1'b0;
            lat_d2r_q <= '0;
            lat_f3_q  <= '0;
            wbv_q     <= 1'b0;
            rw_q      <= 1'b0;
            mis_q     <= 1'b0;
            berr_q    <= 1'b0;
            rd_q      <= '0;
            d2r_q     <= '0;
            pc_q      <= '0;
            alu_q     <= '0;
            off_q     <= '0;
            mdr_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            lat_pc_q  <= lat_pc_d;
            lat_alu_q <= lat_alu_d;
            lat_off_q <= lat_off_d;
            lat_rd_q  <= lat_rd_d;
            lat_rw_q  <= lat_rw_d;
            lat_d2r_q <= lat_d2r_d;
            lat_f3_q  <= lat_f3_d;
            wbv_q     <= wbv_d;
            rw_q      <= rw_d;
            mis_q     <= mis_d;
            berr_q    <= berr_d;
            rd_q      <= rd_d;
            d2r_q     <= d2r_d;
            pc_q      <= pc_d;
            alu_q     <= alu_d;
            off_q     <= off_d;
            mdr_q     <= mdr_d;
        end
    end

    assign stall_o         = (state_q == BUSY);
    assign dmem_req_o      = req_q;
    assign dmem_we_o       = we_q;
    assign dmem_addr_o     = addr_q;
    assign dmem_be_o       = be_q;
    assign dmem_wdata_o    = wdata_q;
    assign wb_valid_o      = wbv_q;
    assign reg_write_o     = rw_q;
    assign rd_o            = rd_q;
    assign dmem_to_reg_o   = d2r_q;
    assign pcsrc_o         = pc_q;
    assign alu_result_o    = alu_q;
    assign offset_o        = off_q;
    assign mem_data_read_o = mdr_q;
    assign misalign_o      = mis_q;
    assign bus_err_o       = berr_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: transaction-level reference model predicting every
// cycle's outputs, randomized bundles and memory latency, plus pinned cases.
module tb_mem_stage;

    localparam int unsigned MAX_WAIT = 15;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b0;
    logic        valid_i = 1'b0;
    logic [31:0] pcsrc_i = '0, alu_result_i = '0, rs2_data_i = '0, offset_i = '0;
    logic [1:0]  dmem_to_reg_i = '0;
    logic        reg_write_i = 1'b0;
    logic [4:0]  rd_i = '0;
    logic        mem_read_i = 1'b0, mem_write_i = 1'b0;
    logic [2:0]  funct3_i = '0;
    logic        stall_o, dmem_req_o, dmem_we_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_rdata_i = '0;
    logic        dmem_ready_i = 1'b0;
    logic        wb_valid_o, reg_write_o, misalign_o, bus_err_o;
    logic [4:0]  rd_o;
    logic [1:0]  dmem_to_reg_o;
    logic [31:0] pcsrc_o, alu_result_o, offset_o, mem_data_read_o;

    always #5 clk_i = ~clk_i;

    mem_stage #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .valid_i(valid_i),
        .pcsrc_i(pcsrc_i), .alu_result_i(alu_result_i), .rs2_data_i(rs2_data_i),
        .offset_i(offset_i), .dmem_to_reg_i(dmem_to_reg_i), .reg_write_i(reg_write_i),
        .rd_i(rd_i), .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
        .funct3_i(funct3_i), .stall_o(stall_o), .dmem_req_o(dmem_req_o),
        .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o),
        .dmem_wdata_o(dmem_wdata_o), .dmem_rdata_i(dmem_rdata_i),
        .dmem_ready_i(dmem_ready_i), .wb_valid_o(wb_valid_o),
        .reg_write_o(reg_write_o), .rd_o(rd_o), .dmem_to_reg_o(dmem_to_reg_o),
        .pcsrc_o(pcsrc_o), .alu_result_o(alu_result_o), .offset_o(offset_o),
        .mem_data_read_o(mem_data_read_o), .misalign_o(misalign_o),
        .bus_err_o(bus_err_o)
    );

    typedef struct packed {
        logic        stall, req, we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        wbv, rw;
        logic [4:0]  rd;
        logic [1:0]  d2r;
        logic [31:0] pc, alu, off, mdr;
        logic        mis, berr;
    } obs_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc, alu, rs2, off;
        logic [1:0]  d2r;
        logic        rw;
        logic [4:0]  rd;
        logic        rdm, wrm;
        logic [2:0]  f3;
    } bnd_t;

    int   n_chk = 0;
    int   n_fail = 0;
    obs_t exp_q[$];
    logic [31:0] seen_addr = '0, seen_wdata = '0;
    logic [3:0]  seen_be = '0;
    logic        seen_we = 1'b0;

    function automatic obs_t observe();
        obs_t o;
        o.stall = stall_o;       o.req = dmem_req_o;     o.we = dmem_we_o;
        o.addr = dmem_addr_o;    o.be = dmem_be_o;       o.wdata = dmem_wdata_o;
        o.wbv = wb_valid_o;      o.rw = reg_write_o;     o.rd = rd_o;
        o.d2r = dmem_to_reg_o;   o.pc = pcsrc_o;         o.alu = alu_result_o;
        o.off = offset_o;        o.mdr = mem_data_read_o;
        o.mis = misalign_o;      o.berr = bus_err_o;
        return o;
    endfunction

    task automatic check_obs(input string name, input obs_t e);
        obs_t a;
        a = observe();
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%h want=%h", name, $time, a, e);
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] a, input logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%h want=%h", name, $time, a, e);
        end
    endtask

    // Reference model: plain arithmetic on the access rules
    function automatic logic m_mis(logic [31:0] a, logic [2:0] f);
        return (f[1:0] == 2'd3) || (f[1:0] == 2'd1 && (a % 2) != 0) ||
               (f[1:0] == 2'd2 && (a % 4) != 0);
    endfunction

    function automatic logic [3:0] m_be(logic [31:0] a, logic [2:0] f);
        if (f[1:0] == 2'd0) return 4'(1 << (a % 4));
        if (f[1:0] == 2'd1) return 4'(3 << (a % 4));
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wdata(logic [31:0] r, logic [2:0] f);
        if (f[1:0] == 2'd0) return {24'b0, r[7:0]} * 32'h0101_0101;
        if (f[1:0] == 2'd1) return {16'b0, r[15:0]} * 32'h0001_0001;
        return r;
    endfunction

    function automatic logic [31:0] m_load(logic [31:0] d, logic [31:0] a, logic [2:0] f);
        logic [31:0] sh, v;
        sh = d >> (8 * (a % 4));
        if (f[1:0] == 2'd0) begin
            v = sh & 32'hFF;
            if (!f[2] && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (f[1:0] == 2'd1) begin
            v = sh & 32'hFFFF;
            if (!f[2] && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end else begin
            v = d;
        end
        return v;
    endfunction

    function automatic obs_t m_out(bnd_t b, logic rw, logic [31:0] mdr, logic mis, logic berr);
        obs_t e;
        e = '0;
        e.wbv = 1'b1; e.rw = rw; e.rd = b.rd; e.d2r = b.d2r;
        e.pc = b.pc; e.alu = b.alu; e.off = b.off; e.mdr = mdr;
        e.mis = mis; e.berr = berr;
        return e;
    endfunction

    function automatic obs_t m_busy(bnd_t b);
        obs_t e;
        e = '0;
        e.stall = 1'b1; e.req = 1'b1; e.we = b.wrm;
        e.addr = b.alu - (b.alu % 4);
        e.be = m_be(b.alu, b.f3);
        e.wdata = b.wrm ? m_wdata(b.rs2, b.f3) : 32'h0;
        return e;
    endfunction

    task automatic drive(input bnd_t b);
        valid_i = b.valid;  pcsrc_i = b.pc;     alu_result_i = b.alu;
        rs2_data_i = b.rs2; offset_i = b.off;   dmem_to_reg_i = b.d2r;
        reg_write_i = b.rw; rd_i = b.rd;        mem_read_i = b.rdm;
        mem_write_i = b.wrm; funct3_i = b.f3;
    endtask

    // One bundle from acceptance to MEM/WB; lat = BUSY cycle that sees ready
    task automatic xact(input bnd_t b, input int lat, input logic [31:0] rdata);
        @(negedge clk_i);
        drive(b);
        dmem_ready_i = 1'($urandom);
        dmem_rdata_i = $urandom;
        if (!b.valid) exp_q.push_back('0);
        else if (!(b.rdm || b.wrm)) exp_q.push_back(m_out(b, b.rw, 32'h0, 1'b0, 1'b0));
        else if (m_mis(b.alu, b.f3)) exp_q.push_back(m_out(b, 1'b0, 32'h0, 1'b1, 1'b0));
        else begin
            exp_q.push_back(m_busy(b));
            for (int j = 1; j <= int'(MAX_WAIT); j++) begin
                @(negedge clk_i);
                dmem_ready_i = (j == lat);
                dmem_rdata_i = (j == lat) ? rdata : $urandom;
                if (j == lat) begin
                    exp_q.push_back(m_out(b, b.rw, b.wrm ? 32'h0 : m_load(rdata, b.alu, b.f3),
                                          1'b0, 1'b0));
                    break;
                end else if (j == int'(MAX_WAIT)) begin
                    exp_q.push_back(m_out(b, 1'b0, 32'h0, 1'b0, 1'b1));
                end else begin
                    exp_q.push_back(m_busy(b));
                end
            end
        end
    endtask

    function automatic bnd_t mk(logic [31:0] alu, logic [4:0] rd, logic rw, logic rdm,
                                logic wrm, logic [2:0] f3, logic [31:0] rs2);
        bnd_t b;
        b.valid = 1'b1; b.pc = 32'h0000_4004; b.alu = alu; b.rs2 = rs2;
        b.off = 32'hFFFF_FFF0; b.d2r = 2'd1; b.rw = rw; b.rd = rd;
        b.rdm = rdm; b.wrm = wrm; b.f3 = f3;
        return b;
    endfunction

    function automatic bnd_t rnd_b();
        bnd_t b;
        int unsigned op;
        op = $urandom_range(0, 3);
        b.valid = ($urandom_range(0, 9) != 0);
        b.pc = $urandom; b.alu = $urandom; b.rs2 = $urandom; b.off = $urandom;
        if ($urandom_range(0, 1) == 0) b.alu[1:0] = 2'b00;
        b.d2r = 2'($urandom); b.rw = 1'($urandom); b.rd = 5'($urandom);
        b.rdm = (op == 1 || op == 3); b.wrm = (op == 2 || op == 3);
        b.f3 = 3'($urandom_range(0, 7));
        return b;
    endfunction

    // Per-cycle compare against the model's prediction for the last edge
    initial begin
        obs_t e;
        forever begin
            @(posedge clk_i);
            #1;
            if (dmem_req_o) begin
                seen_addr = dmem_addr_o; seen_be = dmem_be_o;
                seen_wdata = dmem_wdata_o; seen_we = dmem_we_o;
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_obs("cycle", e);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog t=%0t got=timeout want=finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bnd_t b;
        int   lat;
        #1;
        check_obs("reset_start", '0);
        repeat (2) begin
            @(negedge clk_i);
            exp_q.push_back('0);
        end
        @(negedge clk_i);
        reset_i = 1'b1;
        exp_q.push_back('0);

        // ALU op, one cycle to MEM/WB
        xact(mk(32'h1234, 5'd5, 1'b1, 1'b0, 1'b0, 3'b010, 32'h0), 0, 32'h0);
        @(posedge clk_i); #2;
        check_val("alu_lit", alu_result_o, 32'h1234);
        check_val("alu_wb", {29'b0, wb_valid_o, reg_write_o, stall_o}, 32'b110);

        // LB / LBU from byte 3 with ready in the third BUSY cycle
        xact(mk(32'h103, 5'd7, 1'b1, 1'b1, 1'b0, 3'b000, 32'h0), 3, 32'h80FF_FF7F);
        @(posedge clk_i); #2;
        check_val("lb_lit", mem_data_read_o, 32'hFFFF_FF80);
        check_val("lb_be", {28'b0, seen_be}, 32'h8);
        xact(mk(32'h103, 5'd7, 1'b1, 1'b1, 1'b0, 3'b100, 32'h0), 3, 32'h80FF_FF7F);
        @(posedge clk_i); #2;
        check_val("lbu_lit", mem_data_read_o, 32'h0000_0080);

        // SH to the upper half, immediate ready
        xact(mk(32'h202, 5'd0, 1'b0, 1'b0, 1'b1, 3'b001, 32'hABCD_1234), 1, 32'h0);
        @(posedge clk_i); #2;
        check_val("sh_addr", seen_addr, 32'h200);
        check_val("sh_be", {28'b0, seen_be}, 32'hC);
        check_val("sh_wdata", seen_wdata, 32'h1234_1234);
        check_val("sh_we", {31'b0, seen_we}, 32'h1);

        // Misaligned LW becomes a flagged bubble
        xact(mk(32'h101, 5'd9, 1'b1, 1'b1, 1'b0, 3'b010, 32'h0), 1, 32'h0);
        @(posedge clk_i); #2;
        check_val("lw_mis", {28'b0, wb_valid_o, reg_write_o, misalign_o, dmem_req_o}, 32'b1010);

        // LW with no ready ever: bus timeout
        xact(mk(32'h300, 5'd3, 1'b1, 1'b1, 1'b0, 3'b010, 32'h0), 0, 32'h0);
        @(posedge clk_i); #2;
        check_val("lw_berr", {27'b0, wb_valid_o, reg_write_o, bus_err_o, stall_o, dmem_req_o},
                  32'b10100);

        // Reset asserted in the middle of an access
        b = mk(32'h400, 5'd4, 1'b1, 1'b1, 1'b0, 3'b010, 32'h0);
        @(negedge clk_i);
        drive(b); dmem_ready_i = 1'b0;
        exp_q.push_back(m_busy(b));
        @(negedge clk_i);
        exp_q.push_back(m_busy(b));
        @(negedge clk_i);
        reset_i = 1'b0;
        #1;
        check_obs("reset_mid", '0);
        exp_q.push_back('0);
        @(negedge clk_i);
        exp_q.push_back('0);
        @(negedge clk_i);
        reset_i = 1'b1;
        b.valid = 1'b0;
        drive(b);
        exp_q.push_back('0);

        // Randomized bundles and memory latency
        for (int i = 0; i < 400; i++) begin
            b = rnd_b();
            lat = ($urandom_range(0, 9) < 8) ? int'($urandom_range(1, 4))
                                              : int'($urandom_range(5, MAX_WAIT + 2));
            xact(b, lat, $urandom);
        end

        @(negedge clk_i);
        valid_i = 1'b0;
        exp_q.push_back('0);
        repeat (2) @(posedge clk_i);
        #3;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 5-stage pipeline, directly upstream of the writeback stage. Takes the EX/MEM bundle, performs load/store on the data memory through a req/ready handshake with byte-lane steering and load extension, and drives the MEM/WB pipeline register consumed by writeback. Stalls upstream while a data-memory access is outstanding, and converts misaligned accesses and bus timeouts into harmless bubbles with fault flags.

## Interface
- MAX_WAIT, 15: BUSY cycles without dmem_ready_i before abort (1..255).
- clk_i  in  1  single clock, rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- valid_i  in  1  EX/MEM bundle valid.
- pcsrc_i, alu_result_i, rs2_data_i, offset_i  in  32 each  PC+4, address/ALU result, store data, sign-extended offset.
- dmem_to_reg_i  in  2  writeback mux select (passed through).
- reg_write_i  in  1  register write enable.
- rd_i  in  5  destination register.
- mem_read_i, mem_write_i  in  1 each  load / store.
- funct3_i  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU.
- stall_o  out  1  upstream must hold its bundle.
- dmem_req_o, dmem_we_o  out  1 each  request, write.
- dmem_addr_o  out  32  word address ({alu[31:2],2'b00}).
- dmem_be_o  out  4  byte enables.
- dmem_wdata_o  out  32  lane-replicated store data.
- dmem_rdata_i  in  32; dmem_ready_i  in  1.
- wb_valid_o, reg_write_o  out  1 each; rd_o  out  5; dmem_to_reg_o  out  2.
- pcsrc_o, alu_result_o, offset_o, mem_data_read_o  out  32 each  to writeback.
- misalign_o, bus_err_o  out  1 each  fault flags, valid with wb_valid_o.

## Operation
- FSM states IDLE, BUSY. Reset: IDLE, every output 0.
- IDLE, valid_i=0: MEM/WB loads bubble (wb_valid_o=0, reg_write_o=0).
- IDLE, valid_i=1, no memory op: MEM/WB loads bundle next edge; mem_data_read_o=0.
- IDLE, memory op (mem_write_i wins if both set): fault check first.
  - Fault: funct3[1:0]=11, or H with alu[0]=1, or W with alu[1:0]≠0. No request; MEM/WB loads bundle with reg_write_o=0, misalign_o=1.
  - Else latch bundle, assert dmem_req_o/we/addr/be/wdata (registered), MEM/WB loads bubble, go BUSY, clear wait counter.
- BUSY: stall_o=1; request outputs held stable. Edge with dmem_ready_i=1: MEM/WB loads latched bundle, mem_data_read_o=extended load data (0 for stores), dmem_req_o→0, go IDLE.
- BUSY, counter reaches MAX_WAIT without ready: drop request, MEM/WB loads bundle with reg_write_o=0, bus_err_o=1, go IDLE.
- Store lanes: B be=0001<<alu[1:0], wdata={4{rs2[7:0]}}; H be=alu[1]?1100:0011, wdata={2{rs2[15:0]}}; W be=1111, wdata=rs2.
- Load: select byte by alu[1:0], half by alu[1]; B/H sign-extend, BU/HU zero-extend, W unchanged. dmem_be_o for loads as for stores.
- Fault flags clear on next MEM/WB load.

## Timing
- stall_o combinational = (state==BUSY); includes completion cycle; next bundle accepted first IDLE cycle after.
- Non-memory op: 1 cycle to MEM/WB.
- Memory op accepted edge T0: dmem_req_o high after T0; ready sampled at edge T0+k (k≥1) → wb_valid_o high after T0+k for one cycle; minimum 2 cycles.
- dmem_ready_i ignored in IDLE.
- reset_i low mid-access: dmem_req_o and all outputs drop to 0 immediately, FSM IDLE; access discarded.

## Test plan
- Reset: reset_i=0 mid-BUSY -> dmem_req_o=0 same cycle, all outputs 0, IDLE after release.
- ALU op alu=0x1234, rd=5, reg_write=1 -> next cycle wb_valid_o=1, alu_result_o=0x1234, stall_o=0.
- LB alu=0x103, rdata=0x80FF_FF7F, ready after 3 BUSY cycles -> stall_o 3 cycles, be=1000, mem_data_read_o=0xFFFFFF80; LBU same -> 0x00000080.
- SH alu=0x202, rs2=0xABCD_1234, ready immediate -> addr=0x200, be=1100, wdata=0x12341234, we=1, wb_valid 2 cycles after accept.
- LW alu=0x101 -> no dmem_req_o, next cycle wb_valid_o=1, reg_write_o=0, misalign_o=1.
- LW with ready never asserted, MAX_WAIT=15 -> after 15 BUSY cycles req drops, bus_err_o=1, reg_write_o=0, stall_o releases.
